// File: rtl/fft_scale_pkg.sv
// Shared constants and FSM state type for the FFT inter-stage scaling sequencer.
package fft_scale_pkg;

  localparam int unsigned FP_EXP_MSB = 30;
  localparam int unsigned FP_EXP_LSB = 23;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/fft_scale_sequencer_if.sv
// Config, input-sample and output-sample channels of the scaling sequencer (valid/ready).
interface fft_scale_sequencer_if #(
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned SHIFT_W = 5
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [LEN_W-1:0]   cfg_len;

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_re;
  logic [31:0]        in_img;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_re;
  logic [31:0]        out_img;
  logic               out_last;

  modport master (
    output cfg_valid, cfg_shift, cfg_len, in_valid, in_re, in_img, out_ready,
    input  cfg_ready, in_ready, out_valid, out_re, out_img, out_last
  );

  modport slave (
    input  cfg_valid, cfg_shift, cfg_len, in_valid, in_re, in_img, out_ready,
    output cfg_ready, in_ready, out_valid, out_re, out_img, out_last
  );

endinterface

// File: rtl/fp_pow2_scale.sv
// Combinational divide of one IEEE-754 single by 2^k via exponent subtraction.
module fp_pow2_scale
  import fft_scale_pkg::*;
#(
  parameter int unsigned SHIFT_W = 5
) (
  input  logic [31:0]        din,
  input  logic [SHIFT_W-1:0] k,
  output logic [31:0]        dout,
  output logic               uflow
);

  logic [7:0]         exp_in;
  logic [SHIFT_W+7:0] exp_wide;
  logic [SHIFT_W+7:0] k_wide;

  always_comb begin
    exp_in   = din[FP_EXP_MSB:FP_EXP_LSB];
    exp_wide = {{SHIFT_W{1'b0}}, exp_in};
    k_wide   = {8'b0, k};
    dout     = din;
    uflow    = 1'b0;
    // Zero/denormal is flushed before the k==0 bypass, so denormals never pass through.
    if (exp_in == '0) begin
      dout = {din[31], 31'b0};
    end else if (exp_in == FP_EXP_MAX || k == '0) begin
      dout = din;
    end else if (exp_wide <= k_wide) begin
      dout  = {din[31], 31'b0};
      uflow = 1'b1;
    end else begin
      dout[FP_EXP_MSB:FP_EXP_LSB] = exp_in - k_wide[7:0];
    end
  end

endmodule

// File: rtl/fft_scale_sequencer.sv
// Frame sequencer: one config (k, L) per frame, then L complex samples scaled by 2^-k.
// Optional SCALE_UFLOW_CNT_EN adds a saturating count of underflow-flushed components.
module fft_scale_sequencer
  import fft_scale_pkg::*;
#(
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_scale_sequencer_if.slave bus,
  output logic                 busy
`ifdef SCALE_UFLOW_CNT_EN
  ,
  output logic [15:0]          uflow_cnt
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [31:0]        out_re_q, out_re_d;
  logic [31:0]        out_img_q, out_img_d;

  logic [31:0] sc_re, sc_img;
  logic        uf_re, uf_img;
  logic        in_hs, out_hs, last_in;

  fp_pow2_scale #(.SHIFT_W(SHIFT_W)) u_scale_re (
    .din(bus.in_re), .k(shift_q), .dout(sc_re), .uflow(uf_re)
  );

  fp_pow2_scale #(.SHIFT_W(SHIFT_W)) u_scale_img (
    .din(bus.in_img), .k(shift_q), .dout(sc_img), .uflow(uf_img)
  );

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.in_ready  = (state_q == STREAM) && (!out_valid_q || bus.out_ready);
  assign in_hs         = bus.in_valid && bus.in_ready;
  assign out_hs        = out_valid_q && bus.out_ready;
  assign last_in       = (count_q == len_q - LEN_ONE);

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_img   = out_img_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_img_d   = out_img_q;

    if (in_hs) begin
      out_valid_d = 1'b1;
      out_re_d    = sc_re;
      out_img_d   = sc_img;
      out_last_d  = last_in;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          shift_d = bus.cfg_shift;
          len_d   = (bus.cfg_len == '0) ? LEN_ONE : bus.cfg_len;
          count_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (in_hs) begin
          if (last_in) begin
            count_d = '0;
            state_d = DRAIN;
          end else begin
            count_d = count_q + LEN_ONE;
          end
        end
      end
      // The output register holds the frame's final sample here.
      DRAIN: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_img_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_img_q   <= out_img_d;
    end
  end

`ifdef SCALE_UFLOW_CNT_EN
  logic [1:0]  uf_q, uf_d;
  logic [15:0] uflow_cnt_q, uflow_cnt_d;
  logic [16:0] uflow_sum;

  // Flags travel with the registered sample and are counted when it is handed off.
  always_comb begin
    uf_d        = uf_q;
    uflow_cnt_d = uflow_cnt_q;
    uflow_sum   = {1'b0, uflow_cnt_q} + 17'(uf_q[0]) + 17'(uf_q[1]);
    if (in_hs) uf_d = {uf_img, uf_re};
    if (out_hs) uflow_cnt_d = uflow_sum[16] ? '1 : uflow_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uf_q        <= '0;
      uflow_cnt_q <= '0;
    end else begin
      uf_q        <= uf_d;
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign uflow_cnt = uflow_cnt_q;
`else
  logic unused_uflow;
  assign unused_uflow = uf_re ^ uf_img;
`endif

endmodule

// File: tb/tb_fft_scale_sequencer.sv
// Bench for fft_scale_sequencer: vector table, hand sequences and randomized frames vs a reference model.
module tb_fft_scale_sequencer;

  logic clk;
  logic rst;
  logic busy;
`ifdef SCALE_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
`endif

  fft_scale_sequencer_if #(.LEN_W(10), .SHIFT_W(5)) bus ();

  fft_scale_sequencer #(.LEN_W(10), .SHIFT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
`ifdef SCALE_UFLOW_CNT_EN
    ,
    .uflow_cnt(uflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] img;
    logic        last;
    int          uf;
  } exp_t;

  typedef struct {
    int          k;
    int          len;
    logic [31:0] re;
    logic [31:0] img;
    logic [31:0] ere;
    logic [31:0] eimg;
    int          uf;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          exp_uf = 0;
  int          rdy_mode = 0;
  exp_t        expq[$];
  logic [31:0] sre[$];
  logic [31:0] simg[$];
  vec_t        tbl[10];

  task automatic check_bit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, got no event want event", name);
  endtask

  // Reference: divide by 2^k; a result exponent <= 0 cannot be a normal and is flushed.
  function automatic logic [31:0] ref_comp(input logic [31:0] x, input int k, output int uf);
    int e;
    e  = int'(x[30:23]);
    uf = 0;
    if (e == 0) return {x[31], 31'b0};
    if (e == 255 || k == 0) return x;
    if (e - k <= 0) begin
      uf = 1;
      return {x[31], 31'b0};
    end
    return {x[31], 8'(e - k), x[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r = $urandom;
    int          c = $urandom_range(0, 9);
    case (c)
      0:       r[30:23] = 8'h00;
      1:       r[30:23] = 8'hFF;
      2, 3:    r[30:23] = 8'($urandom_range(1, 32));
      default: ;
    endcase
    return r;
  endfunction

  task automatic push_model(input logic [31:0] re, input logic [31:0] img, input int k, input logic last);
    exp_t e;
    int   u1, u2;
    e.re   = ref_comp(re, k, u1);
    e.img  = ref_comp(img, k, u2);
    e.uf   = u1 + u2;
    e.last = last;
    expq.push_back(e);
  endtask

  task automatic wait_cfg();
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.cfg_ready) begin
        check_bit("cfg_ready_only_idle", busy, 1'b0);
        done = 1;
      end else if (++n > 500) begin
        timeout_fail("cfg_wait");
        done = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_in();
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      else if (++n > 500) begin
        timeout_fail("in_wait");
        done = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int k, input int len, input int gap_max);
    int n;
    bus.cfg_valid = 1'b1;
    bus.cfg_shift = 5'(k);
    bus.cfg_len   = 10'(len);
    wait_cfg();
    bus.cfg_valid = 1'b0;
    n = sre.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 32'(gap_max))) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_re    = sre[i];
      bus.in_img   = simg[i];
      wait_in();
      bus.in_valid = 1'b0;
    end
    sre.delete();
    simg.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    bit done = 0;
    rdy_mode = 0;
    while (!done) begin
      @(negedge clk);
      if (expq.size() == 0 && !busy) done = 1;
      else if (++n > 500) begin
        timeout_fail("drain_wait");
        done = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: order, content, last flag and stability under backpressure.
  logic        stalled = 1'b0;
  logic [31:0] st_re, st_img;
  logic        st_last;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_bit("stall_valid_held", bus.out_valid, 1'b1);
        check_word("stall_re_held", bus.out_re, st_re);
        check_word("stall_img_held", bus.out_img, st_img);
        check_bit("stall_last_held", bus.out_last, st_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          mon_e = expq.pop_front();
          check_word("out_re", bus.out_re, mon_e.re);
          check_word("out_img", bus.out_img, mon_e.img);
          check_bit("out_last", bus.out_last, mon_e.last);
`ifdef SCALE_UFLOW_CNT_EN
          check_word("uflow_cnt", 32'(uflow_cnt), 32'(exp_uf));
`endif
          exp_uf = exp_uf + mon_e.uf;
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      st_re   = bus.out_re;
      st_img  = bus.out_img;
      st_last = bus.out_last;
    end
  end

  initial begin
    int k, len, ln;
    logic [31:0] a, b;

    tbl[0] = '{7,  1, 32'h3F800000, 32'hC0000000, 32'h3C000000, 32'hBC800000, 0};
    tbl[1] = '{7,  1, 32'h00800000, 32'h80000000, 32'h00000000, 32'h80000000, 1};
    tbl[2] = '{31, 1, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000, 0};
    tbl[3] = '{0,  1, 32'h3F800000, 32'h80000001, 32'h3F800000, 32'h80000000, 0};
    tbl[4] = '{31, 1, 32'h4F800000, 32'h3F800000, 32'h40000000, 32'h30000000, 0};
    tbl[5] = '{5,  1, 32'h02800000, 32'h83000000, 32'h00000000, 32'h80800000, 1};
    tbl[6] = '{1,  1, 32'hBF7FFFFF, 32'hFF800000, 32'hBEFFFFFF, 32'hFF800000, 0};
    tbl[7] = '{2,  0, 32'h00000000, 32'h81000000, 32'h00000000, 32'h80000000, 1};
    tbl[8] = '{20, 1, 32'h01000000, 32'h8A000000, 32'h00000000, 32'h80000000, 2};
    tbl[9] = '{7,  0, 32'h3F800000, 32'h00000000, 32'h3C000000, 32'h00000000, 0};

    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_shift = '0; bus.cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_img = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_cfg_ready", bus.cfg_ready, 1'b1);
    check_bit("rst_in_ready", bus.in_ready, 1'b0);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_out_last", bus.out_last, 1'b0);
    check_word("rst_out_re", bus.out_re, 32'h0);
    check_word("rst_out_img", bus.out_img, 32'h0);
    check_bit("rst_busy", busy, 1'b0);
`ifdef SCALE_UFLOW_CNT_EN
    check_word("rst_uflow_cnt", 32'(uflow_cnt), 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // L=1: one-cycle latency, last on first sample, straight to drain.
    bus.cfg_valid = 1'b1; bus.cfg_shift = 5'd7; bus.cfg_len = 10'd1;
    wait_cfg();
    bus.cfg_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_re = 32'h3F800000; bus.in_img = 32'hC0000000;
    expq.push_back('{32'h3C000000, 32'hBC800000, 1'b1, 0});
    @(negedge clk);
    check_bit("t1_in_ready", bus.in_ready, 1'b1);
    check_bit("t1_no_early_out", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_bit("t1_out_valid", bus.out_valid, 1'b1);
    check_bit("t1_out_last", bus.out_last, 1'b1);
    check_bit("t1_busy_drain", busy, 1'b1);
    check_bit("t1_in_ready_drain", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("t1_out_done", bus.out_valid, 1'b0);
    check_bit("t1_busy_idle", busy, 1'b0);
    check_bit("t1_cfg_ready_idle", bus.cfg_ready, 1'b1);
    @(posedge clk); #1;

    // L=4 back-to-back at full throughput.
    bus.cfg_valid = 1'b1; bus.cfg_shift = 5'd7; bus.cfg_len = 10'd4;
    wait_cfg();
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        a = rand_fp(); b = rand_fp();
        bus.in_valid = 1'b1; bus.in_re = a; bus.in_img = b;
        push_model(a, b, 7, c == 3);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 4) check_bit("t2_in_ready", bus.in_ready, 1'b1);
      if (c >= 1 && c <= 4) begin
        check_bit("t2_out_valid", bus.out_valid, 1'b1);
        check_bit("t2_out_last_pos", bus.out_last, c == 4);
      end
      if (c == 5) begin
        check_bit("t2_busy_after", busy, 1'b0);
        check_bit("t2_out_valid_after", bus.out_valid, 1'b0);
      end
      @(posedge clk); #1;
    end

    for (int i = 0; i < 10; i++) begin
      sre.push_back(tbl[i].re);
      simg.push_back(tbl[i].img);
      expq.push_back('{tbl[i].ere, tbl[i].eimg, 1'b1, tbl[i].uf});
      drive_frame(tbl[i].k, tbl[i].len, 1);
    end
    wait_drain();

    // L=8 against alternating out_ready.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      a = rand_fp(); b = rand_fp();
      sre.push_back(a); simg.push_back(b);
      push_model(a, b, 3, i == 7);
    end
    drive_frame(3, 8, 0);
    wait_drain();

    for (int f = 0; f < 40; f++) begin
      k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
      len = int'($urandom_range(0, 12));
      ln = (len == 0) ? 1 : len;
      rdy_mode = int'($urandom_range(0, 2));
      for (int i = 0; i < ln; i++) begin
        a = rand_fp(); b = rand_fp();
        sre.push_back(a); simg.push_back(b);
        push_model(a, b, k, i == ln - 1);
      end
      drive_frame(k, len, int'($urandom_range(0, 2)));
    end
    wait_drain();

    // Reset after the 3rd of 8 samples, with handshakes offered during reset.
    bus.cfg_valid = 1'b1; bus.cfg_shift = 5'd7; bus.cfg_len = 10'd8;
    wait_cfg();
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a = rand_fp(); b = rand_fp();
      bus.in_valid = 1'b1; bus.in_re = a; bus.in_img = b;
      push_model(a, b, 7, 1'b0);
      @(negedge clk);
      check_bit("t6_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.cfg_valid = 1'b1; bus.cfg_len = 10'd2;
    bus.in_re = rand_fp(); bus.in_img = rand_fp();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_bit("t6_out_valid", bus.out_valid, 1'b0);
    check_bit("t6_busy", busy, 1'b0);
    check_bit("t6_cfg_ready", bus.cfg_ready, 1'b1);
    check_bit("t6_in_ready", bus.in_ready, 1'b0);
    check_word("t6_outputs_before_rst", 32'(expq.size()), 32'd1);
`ifdef SCALE_UFLOW_CNT_EN
    check_word("t6_uflow_cleared", 32'(uflow_cnt), 32'h0);
`endif
    expq.delete();
    exp_uf = 0;
    @(posedge clk); #1;
    k = int'($urandom_range(1, 31));
    for (int i = 0; i < 2; i++) begin
      a = rand_fp(); b = rand_fp();
      sre.push_back(a); simg.push_back(b);
      push_model(a, b, k, i == 1);
    end
    drive_frame(k, 2, 0);
    wait_drain();

    @(negedge clk);
    check_bit("end_busy", busy, 1'b0);
    check_bit("end_cfg_ready", bus.cfg_ready, 1'b1);
`ifdef SCALE_UFLOW_CNT_EN
    check_word("end_uflow_cnt", 32'(uflow_cnt), 32'(exp_uf));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

endmodule
